// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 IDCT transpose buffer.
// Index widths and a wrap-around counter helper.
package dct_pkg;

  localparam int DCT_N = 8;
  localparam int IDX_W = 3;
  localparam int DEF_W = 16;
  localparam int NBANK = 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic signed [DCT_N-1:0][DEF_W-1:0] row_t;

  localparam idx_t IDX_LAST = idx_t'(DCT_N - 1);

  function automatic idx_t idx_inc(input idx_t v);
    return idx_t'(v + idx_t'(1));
  endfunction

endpackage

// File: rtl/dct_tr_bank.sv
// One 8x8 storage bank: row-wide write port, column-wide read mux.
// Contents are deliberately not reset; validity is tracked by the caller.
module dct_tr_bank
  import dct_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  idx_t                        i_row,
  input  logic [DCT_N-1:0][W-1:0]     i_row_data,
  input  idx_t                        i_col,
  output logic [DCT_N-1:0][W-1:0]     o_col_data
);

  logic [DCT_N-1:0][W-1:0] r_mem [DCT_N];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_row] <= i_row_data;
    end
  end

  always_comb begin
    o_col_data = '0;
    for (int i = 0; i < DCT_N; i++) begin
      o_col_data[i] = r_mem[i][i_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between IDCT row and column passes.
// One bank fills row-wise while the other drains column-wise.
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DCT_N-1:0][W-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DCT_N-1:0][W-1:0] out_data,
  output logic                           out_last
);

  logic [NBANK-1:0] r_full;
  logic [NBANK-1:0] w_full_nxt;
  logic             r_wr_sel;
  logic             r_rd_sel;
  idx_t             r_row_cnt;
  idx_t             r_col_cnt;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_row_done;
  logic             w_col_done;
  logic [NBANK-1:0] w_we;

  logic [DCT_N-1:0][W-1:0] w_col [NBANK];

  assign in_ready   = ~r_full[r_wr_sel];
  assign out_valid  = r_full[r_rd_sel];
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_row_done = w_in_fire & (r_row_cnt == IDX_LAST);
  assign w_col_done = w_out_fire & (r_col_cnt == IDX_LAST);

  assign w_we[0] = w_in_fire & ~r_wr_sel;
  assign w_we[1] = w_in_fire &  r_wr_sel;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    dct_tr_bank #(
      .W(W)
    ) u_bank (
      .clk        (clk),
      .i_we       (w_we[b]),
      .i_row      (r_row_cnt),
      .i_row_data (in_data),
      .i_col      (r_col_cnt),
      .o_col_data (w_col[b])
    );
  end

  // Fill and drain always target different banks, so set/clear never collide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_row_done) begin
      w_full_nxt[r_wr_sel] = 1'b1;
    end
    if (w_col_done) begin
      w_full_nxt[r_rd_sel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_in_fire) begin
        r_row_cnt <= idx_inc(r_row_cnt);
      end
      if (w_row_done) begin
        r_wr_sel <= ~r_wr_sel;
      end
      if (w_out_fire) begin
        r_col_cnt <= idx_inc(r_col_cnt);
      end
      if (w_col_done) begin
        r_rd_sel <= ~r_rd_sel;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = r_rd_sel ? w_col[1] : w_col[0];
    end
  end

  assign out_last = out_valid & (r_col_cnt == IDX_LAST);

endmodule
